upower_exec_unit: RTL and testbench



---
 rtl/upower_exec_unit_pkg.sv | 30 +++
 rtl/upower_exec_unit_alu64.sv | 28 ++
 rtl/upower_exec_unit.sv | 102 ++++++++++
 tb/tb_upower_exec_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/upower_exec_unit_pkg.sv
// upower_exec_unit_pkg: opcode/XO constants and alu_ctrl encodings shared by the uPOWER execute unit
package upower_exec_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd31;
  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_ANDI = 6'd28;
  localparam logic [5:0] OP_ORI = 6'd24;
  localparam logic [5:0] OP_XORI = 6'd26;
  localparam logic [5:0] OP_LD = 6'd58;
  localparam logic [5:0] OP_STD = 6'd62;
  localparam logic [5:0] OP_BEQ = 6'd19;
  localparam logic [5:0] OP_B = 6'd18;
  localparam logic [8:0] XO_ADD = 9'd266;
  localparam logic [8:0] XO_SUB = 9'd40;
  localparam logic [8:0] XO_AND = 9'd28;
  localparam logic [8:0] XO_OR = 9'd444;
  localparam logic [8:0] XO_XOR = 9'd316;
  localparam logic [8:0] XO_NOR = 9'd124;
  localparam logic [8:0] XO_NAND = 9'd476;
  localparam logic [8:0] XO_SLT = 9'd0;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_NAND = 4'b1101
  } alu_ctrl_e;
endpackage

// File: rtl/upower_exec_unit_alu64.sv
// alu64: combinational 64-bit ALU; in a, b, ctrl; out result, zero, overflow (signed, ADD/SUB only)
module alu64
  import upower_exec_unit_pkg::*;
(
  input logic [63:0] a,
  input logic [63:0] b,
  input alu_ctrl_e ctrl,
  output logic [63:0] result,
  output logic zero,
  output logic overflow
);
  logic [63:0] sum, diff;
  always_comb begin
    sum = a + b;
    diff = a - b;
    result = ctrl == ALU_AND ? a & b :
             ctrl == ALU_OR ? a | b :
             ctrl == ALU_ADD ? sum :
             ctrl == ALU_XOR ? a ^ b :
             ctrl == ALU_SUB ? diff :
             ctrl == ALU_SLT ? {63'd0, $signed(a) < $signed(b)} :
             ctrl == ALU_NOR ? ~(a | b) :
             ctrl == ALU_NAND ? ~(a & b) : 64'd0;
    overflow = ctrl == ALU_ADD ? (a[63] == b[63]) && (sum[63] != a[63]) :
               ctrl == ALU_SUB ? (a[63] != b[63]) && (diff[63] != a[63]) : 1'b0;
  end
  assign zero = result == 64'd0;
endmodule

// File: rtl/upower_exec_unit.sv
// upower_exec_unit: decode + operand mux + alu64, registered to EX/MEM; in clk, reset(async low), in_valid, instr, read_data1/2; out valid, result, flags, alu_ctrl, store_data, strobes
module upower_exec_unit
  import upower_exec_unit_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic in_valid,
  input logic [31:0] instr,
  input logic [63:0] read_data1,
  input logic [63:0] read_data2,
  output logic out_valid,
  output logic [63:0] alu_result,
  output logic zero,
  output logic overflow,
  output logic [3:0] alu_ctrl,
  output logic [63:0] store_data,
  output logic reg_dst,
  output logic alu_src,
  output logic mem_to_reg,
  output logic reg_write,
  output logic mem_read,
  output logic mem_write,
  output logic branch,
  output logic jump
);
  logic [5:0] opcode;
  logic [8:0] xo;
  logic [7:0] ctl;
  logic [1:0] alu_op;
  logic zext;
  logic [63:0] imm, op2, result;
  logic res_zero, res_ovf;
  alu_ctrl_e ctrl;
  logic unused_bits;
  assign opcode = instr[31:26];
  assign xo = instr[9:1];
  assign unused_bits = ^instr[25:16] ^ instr[0];
  // ctl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
  always_comb begin
    ctl = 8'b0;
    alu_op = 2'b00;
    zext = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctl = 8'b1001_0000; alu_op = 2'b10; end
      OP_ADDI: ctl = 8'b0101_0000;
      OP_ANDI, OP_ORI, OP_XORI: begin ctl = 8'b0101_0000; alu_op = 2'b11; zext = 1'b1; end
      OP_LD: ctl = 8'b0111_1000;
      OP_STD: ctl = 8'b0100_0100;
      OP_BEQ: begin ctl = 8'b0000_0010; alu_op = 2'b01; end
      OP_B: ctl = 8'b0000_0001;
      default: ;
    endcase
  end
  always_comb begin
    ctrl = ALU_ADD;
    if (alu_op == 2'b01) ctrl = ALU_SUB;
    else if (alu_op == 2'b11)
      ctrl = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_XOR;
    else if (alu_op == 2'b10)
      case (xo)
        XO_SUB: ctrl = ALU_SUB;
        XO_AND: ctrl = ALU_AND;
        XO_OR: ctrl = ALU_OR;
        XO_XOR: ctrl = ALU_XOR;
        XO_NOR: ctrl = ALU_NOR;
        XO_NAND: ctrl = ALU_NAND;
        XO_SLT: ctrl = ALU_SLT;
        default: ctrl = ALU_ADD;
      endcase
  end
  assign imm = zext ? {48'd0, instr[15:0]} : {{48{instr[15]}}, instr[15:0]};
  assign op2 = ctl[6] ? imm : read_data2;
  alu64 u_alu (
    .a(read_data1),
    .b(op2),
    .ctrl(ctrl),
    .result(result),
    .zero(res_zero),
    .overflow(res_ovf)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump} <= 8'b0;
      alu_result <= 64'd0;
      zero <= 1'b0;
      overflow <= 1'b0;
      alu_ctrl <= 4'd0;
      store_data <= 64'd0;
    end else begin
      out_valid <= in_valid;
      {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump} <= in_valid ? ctl : 8'b0;
      if (in_valid) begin
        alu_result <= result;
        zero <= res_zero;
        overflow <= res_ovf;
        alu_ctrl <= ctrl;
        store_data <= read_data2;
      end
    end
  end
endmodule

// File: tb/tb_upower_exec_unit.sv
// tb_upower_exec_unit: directed vectors with hand-computed expectations for upower_exec_unit
module tb_upower_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid;
  logic [31:0] instr;
  logic [63:0] read_data1, read_data2;
  logic out_valid, zero, overflow;
  logic [63:0] alu_result, store_data;
  logic [3:0] alu_ctrl;
  logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
  int pass_cnt = 0;
  int total_cnt = 0;
  always #5 clk = ~clk;
  upower_exec_unit dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .instr(instr),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .out_valid(out_valid),
    .alu_result(alu_result),
    .zero(zero),
    .overflow(overflow),
    .alu_ctrl(alu_ctrl),
    .store_data(store_data),
    .reg_dst(reg_dst),
    .alu_src(alu_src),
    .mem_to_reg(mem_to_reg),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .branch(branch),
    .jump(jump)
  );
  logic [7:0] strobes;
  assign strobes = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = v;
    instr = i;
    read_data1 = a;
    read_data2 = b;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rtype(input logic [8:0] xo);
    return {6'd31, 15'd0, 1'b0, xo, 1'b0};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction
  initial begin
    in_valid = 1'b1;
    instr = rtype(9'd266);
    read_data1 = 64'h1234;
    read_data2 = 64'h5678;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", alu_result, 64'd0);
    chk("rst_flags", {58'd0, zero, overflow, alu_ctrl}, 64'd0);
    chk("rst_store", store_data, 64'd0);
    chk("rst_strobes", {56'd0, strobes}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1, itype(6'd14, 16'hFFFF), 64'd5, 64'd99);
    chk("addi_result", alu_result, 64'd4);
    chk("addi_strobes", {56'd0, strobes}, 64'h50);
    chk("addi_zero", {63'd0, zero}, 64'd0);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    step(1, rtype(9'd40), 64'd7, 64'd7);
    chk("sub_result", alu_result, 64'd0);
    chk("sub_zero", {63'd0, zero}, 64'd1);
    chk("sub_ctrl", {60'd0, alu_ctrl}, 64'h6);
    chk("sub_strobes", {56'd0, strobes}, 64'h90);
    step(1, rtype(9'd266), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_ovf_result", alu_result, 64'h8000_0000_0000_0000);
    chk("add_ovf", {63'd0, overflow}, 64'd1);
    chk("add_ctrl", {60'd0, alu_ctrl}, 64'h2);
    step(1, rtype(9'd40), 64'h8000_0000_0000_0000, 64'd1);
    chk("sub_ovf_result", alu_result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf", {63'd0, overflow}, 64'd1);
    step(1, rtype(9'd0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("slt_result", alu_result, 64'd1);
    chk("slt_ctrl", {60'd0, alu_ctrl}, 64'h7);
    step(1, rtype(9'd124), 64'd0, 64'd0);
    chk("nor_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nor_ctrl", {60'd0, alu_ctrl}, 64'hC);
    step(1, rtype(9'd476), 64'hF0, 64'hFF);
    chk("nand_result", alu_result, 64'hFFFF_FFFF_FFFF_FF0F);
    step(1, rtype(9'd5), 64'd3, 64'd4);
    chk("badxo_result", alu_result, 64'd7);
    chk("badxo_ctrl", {60'd0, alu_ctrl}, 64'h2);
    step(1, itype(6'd24, 16'h8000), 64'd0, 64'd77);
    chk("ori_result", alu_result, 64'h8000);
    chk("ori_ctrl", {60'd0, alu_ctrl}, 64'h1);
    step(1, itype(6'd28, 16'hFF0F), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    chk("andi_result", alu_result, 64'hFF0F);
    step(1, itype(6'd58, 16'hFFF8), 64'd8, 64'd1);
    chk("ld_result", alu_result, 64'd0);
    chk("ld_zero", {63'd0, zero}, 64'd1);
    chk("ld_strobes", {56'd0, strobes}, 64'h78);
    step(1, itype(6'd62, 16'd8), 64'd16, 64'd42);
    chk("std_result", alu_result, 64'd24);
    chk("std_strobes", {56'd0, strobes}, 64'h44);
    chk("std_store", store_data, 64'd42);
    step(1, itype(6'd19, 16'h0004), 64'd9, 64'd4);
    chk("beq_result", alu_result, 64'd5);
    chk("beq_ctrl", {60'd0, alu_ctrl}, 64'h6);
    chk("beq_strobes", {56'd0, strobes}, 64'h02);
    step(1, itype(6'd18, 16'h0100), 64'd1, 64'd2);
    chk("b_result", alu_result, 64'd3);
    chk("b_strobes", {56'd0, strobes}, 64'h01);
    step(1, itype(6'd0, 16'h0000), 64'd10, 64'd20);
    chk("unk_result", alu_result, 64'd30);
    chk("unk_strobes", {56'd0, strobes}, 64'h00);
    chk("unk_valid", {63'd0, out_valid}, 64'd1);
    step(0, rtype(9'd40), 64'd100, 64'd1);
    chk("bubble_valid", {63'd0, out_valid}, 64'd0);
    chk("bubble_strobes", {56'd0, strobes}, 64'h00);
    chk("bubble_hold", alu_result, 64'd30);
    chk("bubble_store", store_data, 64'd20);
    chk("bubble_ctrl", {60'd0, alu_ctrl}, 64'h2);
    @(negedge clk);
    in_valid = 1'b1;
    instr = itype(6'd14, 16'd1);
    read_data1 = 64'd50;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_result", alu_result, 64'd0);
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_discard", alu_result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1, itype(6'd14, 16'd1), 64'd50, 64'd0);
    chk("post_rst_result", alu_result, 64'd51);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
